// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter front end.
// Lane count and index width are fixed by the arbiter.
package arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int LANE_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GWAIT = 2'd1,
    XFER  = 2'd2
  } arb_st_e;

  function automatic logic onehot_chk(input logic [NUM_REQ-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/arb_req_mux_onehot_enc.sv
// Grant vector encoder: index of the lowest set bit, plus one-hot and zero flags.
// Purely combinational; for a one-hot input the index is the exact owner.
module onehot_enc
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  output logic [LANE_W-1:0]  idx,
  output logic               is_onehot,
  output logic               is_zero
);

  // Scan downward so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = LANE_W'(i);
    end
  end

  assign is_onehot = onehot_chk(vec);
  assign is_zero   = (vec == '0);

endmodule

// File: rtl/arb_req_mux.sv
// Requester front end for the 16-way arbiter: one request per packet, holds the grant for the whole packet.
// Optional grant checking with sticky err_gnt is enabled by defining ARB_REQ_MUX_CHECK_EN.
module arb_req_mux #(
  parameter int DW      = 32,
  parameter int NUM_REQ = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         in_valid,
  output logic [NUM_REQ-1:0]         in_ready,
  input  logic [NUM_REQ*DW-1:0]      in_data,
  input  logic [NUM_REQ-1:0]         in_last,
  output logic [NUM_REQ-1:0]         arb_req,
  input  logic [NUM_REQ-1:0]         arb_gnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic                       out_last,
  output logic [arb_pkg::LANE_W-1:0] out_lane,
  output logic                       err_gnt
);

  import arb_pkg::*;

  arb_st_e             state_q, state_d;
  logic [LANE_W-1:0]   owner_q;
  logic [LANE_W-1:0]   gnt_idx;
  logic                gnt_onehot;
  logic                gnt_zero;
  logic                gnt_ok;

  onehot_enc u_enc (
    .vec       (arb_gnt),
    .idx       (gnt_idx),
    .is_onehot (gnt_onehot),
    .is_zero   (gnt_zero)
  );

`ifdef ARB_REQ_MUX_CHECK_EN
  logic [NUM_REQ-1:0] req_q;
  logic               err_q;

  // A legal grant names exactly one lane that actually requested.
  assign gnt_ok = gnt_onehot && ((arb_gnt & ~req_q) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && (|in_valid)) req_q <= in_valid;
      if (state_q == GWAIT && !gnt_ok)    err_q <= 1'b1;
    end
  end

  assign err_gnt = err_q;

  a_gnt_legal: assert property (@(posedge clk) disable iff (rst) (state_q == GWAIT) |-> gnt_ok);
`else
  logic unused_gnt_onehot;

  assign gnt_ok            = !gnt_zero;
  assign err_gnt           = 1'b0;
  assign unused_gnt_onehot = gnt_onehot;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == GWAIT && gnt_ok) owner_q <= gnt_idx;
    end
  end

  always_comb begin
    state_d   = state_q;
    arb_req   = '0;
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        arb_req = in_valid;
        if (|in_valid) state_d = GWAIT;
      end
      GWAIT: begin
        state_d = gnt_ok ? XFER : IDLE;
      end
      XFER: begin
        out_valid         = in_valid[owner_q];
        out_data          = in_data[int'(owner_q) * DW +: DW];
        out_last          = in_last[owner_q];
        in_ready[owner_q] = out_ready;
        if (out_valid && out_ready && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_lane = owner_q;

endmodule

// File: doc/arb_req_mux.md
# arb_req_mux

Requester-side front end for the 16-way round-robin arbiter. It collects packet streams from 16 client lanes and drives the arbiter's `req[15:0]`. It consumes the arbiter's registered one-hot `gnt[15:0]` and forwards the granted lane's whole packet onto one shared valid/ready output. The block holds one grant for a complete multi-beat packet and issues exactly one arbitration request per packet, so the arbiter's rotation advances once per packet.

## Interface
Parameters:
- `DW`, 32: payload width per lane.
- `NUM_REQ`, 16: lane count; fixed to match the arbiter.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 16: per-lane beat valid.
- `in_ready`, output, 16: per-lane beat accept.
- `in_data`, input, 16*DW: lane i occupies bits [i*DW +: DW].
- `in_last`, input, 16: per-lane last beat of packet.
- `arb_req`, output, 16: request vector to the arbiter.
- `arb_gnt`, input, 16: registered one-hot grant from the arbiter.
- `out_valid`, output, 1: shared beat valid.
- `out_ready`, input, 1: shared beat accept.
- `out_data`, output, DW: shared payload.
- `out_last`, output, 1: shared last-beat flag.
- `out_lane`, output, 4: index of the current owner lane.
- `err_gnt`, output, 1: sticky grant-protocol error.

## Operation
- States: IDLE, GWAIT, XFER.
- IDLE:
  - `arb_req = in_valid`.
  - If `|in_valid`, snapshot `req_q <= in_valid` and go to GWAIT. Otherwise stay in IDLE.
- GWAIT:
  - `arb_req = 0`.
  - Sample `arb_gnt`. A valid grant is one-hot and a subset of `req_q`; latch `owner <= encode(arb_gnt)` and go to XFER.
  - Invalid grant (zero, multi-hot, or not in `req_q`): go to IDLE with no transfer; see Configuration.
- XFER:
  - `arb_req = 0`.
  - `out_valid = in_valid[owner]`, `out_data = in_data[owner]`, `out_last = in_last[owner]`.
  - `in_ready[owner] = out_ready`; all other `in_ready` bits are 0.
  - A beat transfers when `out_valid & out_ready`.
  - When the transferred beat has `out_last`, go to IDLE. Otherwise stay in XFER.
- `in_ready` is 0 for every lane outside XFER.
- `out_valid` is 0 outside XFER.
- `out_lane = owner` in every state.
- Clients obey valid/ready stability: once `in_valid[i]` is raised it stays high with stable data until accepted. The granted lane is therefore still valid on entry to XFER.
- Packet length is unbounded. The owner keeps the output until its last beat.
- A lane deasserting `in_valid` mid-packet simply stalls XFER. This is legal; there is no timeout.

## Timing
- Reset values:
  - State IDLE, `owner = 0`, `req_q = 0`, `err_gnt = 0`.
  - All outputs are 0, except `arb_req`, which reflects `in_valid` because the block is in IDLE.
- Arbitration latency: `in_valid` rises in cycle t (IDLE) → grant is visible in cycle t+1 (GWAIT) → first beat can transfer in cycle t+2.
- Packet gap: a last beat accepted in cycle u → IDLE in u+1 → next first beat no earlier than u+3. Overhead is 2 cycles per packet.
- `arb_req` is nonzero for exactly one cycle per packet. The arbiter's `gnt` is therefore 0 again by the cycle after GWAIT.
- `arb_gnt` is ignored in IDLE and XFER.
- Single-beat packet: IDLE, GWAIT, XFER, then IDLE; 3 cycles minimum.
- Wrap-around: owner index 15 followed by 0 needs no special handling; the rotation is the arbiter's.
- Reset mid-XFER: the packet is abandoned, and `in_ready`/`out_valid` drop asynchronously. The client re-presents the beat after reset.

## Configuration
- `ARB_REQ_MUX_CHECK_EN` defined:
  - GWAIT checks the grant. An invalid grant sets `err_gnt` (sticky until `rst`) and returns to IDLE.
  - A simulation assertion also fires on the invalid grant.
- Macro undefined:
  - `err_gnt` is tied to 0 and no `req_q` comparison is made.
  - GWAIT takes the lowest set bit of `arb_gnt` as owner.
  - `arb_gnt == 0` returns to IDLE.

## Structure
- Shared package `arb_pkg`:
  - `NUM_REQ = 16`, `LANE_W = 4`.
  - `arb_st_e` enum {IDLE, GWAIT, XFER}.
  - Function `onehot_chk`.
- Sub-module `onehot_enc`: 16-bit one-hot to 4-bit index, plus `is_onehot` and `is_zero` flags. It is used for owner encode and for the checker.

## Test plan
- Lane 5 sends a 3-beat packet with data 0xA0..0xA2 and `out_ready = 1`:
  - `arb_req = 0x0020` for exactly one cycle.
  - `out_lane = 5`.
  - Beats appear in cycles t+2..t+4 with `out_last` on 0xA2.
- All 16 lanes send 1-beat packets continuously: `out_lane` sequence follows the arbiter rotation 0,1,…,15,0 with no repeats.
- Lane 3 sends a 4-beat packet while `out_ready` toggles 1,0,0,1…:
  - No beat is lost or duplicated.
  - `in_ready[3]` equals `out_ready`.
  - Other `in_ready` bits stay 0.
- Assert `rst` during beat 2 of a lane-9 packet:
  - `out_valid`, `in_ready` and `err_gnt` are 0 immediately.
  - The next arbitration restarts from IDLE.
- With `ARB_REQ_MUX_CHECK_EN`:
  - Drive `arb_gnt = 0x0003` in GWAIT → `err_gnt` = 1, back to IDLE, no `out_valid`.
  - Drive `arb_gnt = 0x0100` with `req_q = 0x0001` → `err_gnt` = 1.
- Without the macro, drive `arb_gnt = 0x0003` → `out_lane = 0` and the transfer completes.
